// File: rtl/seg7_scan_driver_if.sv
// Display bus for seg7_scan_driver: digit codes, decimal points and enable in,
// multiplexed segment/anode/dp pins out.
interface seg7_scan_driver_if;
  logic       en;
  logic [3:0] d3;
  logic [3:0] d2;
  logic [3:0] d1;
  logic [3:0] d0;
  logic [3:0] dp_in;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output en, d3, d2, d1, d0, dp_in,
    input  seg, dp, an
  );

  modport slave (
    input  en, d3, d2, d1, d0, dp_in,
    output seg, dp, an
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver with anti-ghosting guard band.
// Define SEG7_HEX_EN to decode codes 10..15 as A,b,C,d,E,F (otherwise blank).
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 16,
  parameter int COMMON_ANODE = 1
) (
  input logic                clk,
  input logic                reset,
  seg7_scan_driver_if.slave  bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST     = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD_M1 = CW'(GUARD - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [6:0]    SEG_OFF      = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
  localparam logic [3:0]    AN_OFF       = (COMMON_ANODE != 0) ? 4'hF : 4'h0;
  localparam logic          DP_OFF       = (COMMON_ANODE != 0) ? 1'b1 : 1'b0;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [19:0]   r_shadow;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_dp;

  logic          w_wrap;
  logic [3:0]    w_digit;
  logic          w_dp_sel;
  logic [6:0]    w_seg_ah;
  logic [3:0]    w_an_ah;
  logic          w_dp_ah;

  // Active-high segment pattern {g,f,e,d,c,b,a}; unsupported codes blank.
  function automatic logic [6:0] f_decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
`ifdef SEG7_HEX_EN
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      4'hF:    pat = 7'h71;
`endif
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  assign w_wrap = (r_cnt == CNT_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_GUARD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; DRIVE is entered on the edge where cnt becomes GUARD
  always_comb begin
    w_state_nxt = r_state;
    if (!bus.en) begin
      w_state_nxt = ST_GUARD;
    end else begin
      case (r_state)
        ST_GUARD: w_state_nxt = (r_cnt == CNT_GUARD_M1) ? ST_DRIVE : ST_GUARD;
        ST_DRIVE: w_state_nxt = w_wrap ? ST_GUARD : ST_DRIVE;
        default:  w_state_nxt = ST_GUARD;
      endcase
    end
  end

  // Slot counter, digit index and frame-atomic shadow of the inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_shadow <= 20'h00000;
    end else if (!bus.en) begin
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_shadow <= {bus.d3, bus.d2, bus.d1, bus.d0, bus.dp_in};
    end else begin
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          r_shadow <= {bus.d3, bus.d2, bus.d1, bus.d0, bus.dp_in};
        end else begin
          r_shadow <= r_shadow;
        end
      end else begin
        r_cnt    <= r_cnt + CNT_ONE;
        r_idx    <= r_idx;
        r_shadow <= r_shadow;
      end
    end
  end

  // Output decode; en gates the pins immediately so a disable blanks on the next edge
  always_comb begin
    w_digit  = 4'h0;
    w_dp_sel = 1'b0;
    w_seg_ah = 7'h00;
    w_an_ah  = 4'h0;
    w_dp_ah  = 1'b0;
    case (r_idx)
      2'd0:    begin w_digit = r_shadow[7:4];   w_dp_sel = r_shadow[0]; end
      2'd1:    begin w_digit = r_shadow[11:8];  w_dp_sel = r_shadow[1]; end
      2'd2:    begin w_digit = r_shadow[15:12]; w_dp_sel = r_shadow[2]; end
      2'd3:    begin w_digit = r_shadow[19:16]; w_dp_sel = r_shadow[3]; end
      default: begin w_digit = 4'h0;            w_dp_sel = 1'b0;        end
    endcase
    if (bus.en && (r_state == ST_DRIVE)) begin
      w_an_ah  = 4'b0001 << r_idx;
      w_seg_ah = f_decode(w_digit);
      w_dp_ah  = w_dp_sel;
    end else begin
      w_an_ah  = 4'h0;
      w_seg_ah = 7'h00;
      w_dp_ah  = 1'b0;
    end
  end

  // Registered pins with polarity applied
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg <= SEG_OFF;
      r_an  <= AN_OFF;
      r_dp  <= DP_OFF;
    end else begin
      r_seg <= w_seg_ah ^ SEG_OFF;
      r_an  <= w_an_ah ^ AN_OFF;
      r_dp  <= w_dp_ah ^ DP_OFF;
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;
  assign bus.dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (SCAN_DIV=8, GUARD=2, common anode).
module tb_seg7_scan_driver;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(
    .SCAN_DIV     (8),
    .GUARD        (2),
    .COMMON_ANODE (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEG7_HEX_EN
  localparam logic [6:0] PIN_C = 7'h46;
`else
  localparam logic [6:0] PIN_C = 7'h7F;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_pins(input logic [3:0] an_e, input logic [6:0] seg_e, input logic dp_e);
    chk("an",  {4'h0, bus.an},  {4'h0, an_e});
    chk("seg", {1'b0, bus.seg}, {1'b0, seg_e});
    chk("dp",  {7'h00, bus.dp}, {7'h00, dp_e});
  endtask

  // Two blank guard edges, then n_drive edges with the given digit showing
  task automatic run_slot(input logic [3:0] an_e, input logic [6:0] seg_e,
                          input logic dp_e, input int n_drive);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_pins(4'hF, 7'h7F, 1'b1);
    end
    for (int i = 0; i < n_drive; i++) begin
      tick();
      chk_pins(an_e, seg_e, dp_e);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.en      = 1'b1;
    bus.d3      = 4'd1;
    bus.d2      = 4'd2;
    bus.d1      = 4'd3;
    bus.d0      = 4'd4;
    bus.dp_in   = 4'b0000;

    // reset state
    tick(); chk_pins(4'hF, 7'h7F, 1'b1);
    tick(); chk_pins(4'hF, 7'h7F, 1'b1);

    // release with display disabled so the shadow captures 1,2,3,4
    reset  = 1'b0;
    bus.en = 1'b0;
    tick(); chk_pins(4'hF, 7'h7F, 1'b1);
    bus.en = 1'b1;

    // full frame: digits 4,3,2,1 on an E,D,B,7
    run_slot(4'hE, 7'h19, 1'b1, 6);
    run_slot(4'hD, 7'h30, 1'b1, 6);
    run_slot(4'hB, 7'h24, 1'b1, 6);
    run_slot(4'h7, 7'h79, 1'b1, 6);

    // mid-frame change must wait for the frame boundary
    run_slot(4'hE, 7'h19, 1'b1, 6);
    bus.d0 = 4'd9;
    bus.d2 = 4'd5;
    run_slot(4'hD, 7'h30, 1'b1, 6);
    run_slot(4'hB, 7'h24, 1'b1, 6);
    run_slot(4'h7, 7'h79, 1'b1, 6);
    run_slot(4'hE, 7'h10, 1'b1, 6);

    // drop enable mid-DRIVE of digit 1
    run_slot(4'hD, 7'h30, 1'b1, 3);
    bus.en = 1'b0;
    bus.d0 = 4'hC;
    tick(); chk_pins(4'hF, 7'h7F, 1'b1);
    tick(); chk_pins(4'hF, 7'h7F, 1'b1);
    bus.en = 1'b1;
    run_slot(4'hE, PIN_C, 1'b1, 6);
    run_slot(4'hD, 7'h30, 1'b1, 6);

    // reset at cnt=5 of digit 2
    bus.dp_in = 4'b0100;
    run_slot(4'hB, 7'h12, 1'b1, 3);
    reset = 1'b1;
    tick(); chk_pins(4'hF, 7'h7F, 1'b1);
    tick(); chk_pins(4'hF, 7'h7F, 1'b1);
    reset = 1'b0;

    // cleared shadow shows 0 until the first frame boundary
    run_slot(4'hE, 7'h40, 1'b1, 6);
    run_slot(4'hD, 7'h40, 1'b1, 6);
    run_slot(4'hB, 7'h40, 1'b1, 6);
    run_slot(4'h7, 7'h40, 1'b1, 6);

    // reloaded frame: dp lit only on digit 2
    run_slot(4'hE, PIN_C, 1'b1, 6);
    run_slot(4'hD, 7'h30, 1'b1, 6);
    run_slot(4'hB, 7'h12, 1'b0, 6);
    run_slot(4'h7, 7'h79, 1'b1, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clock cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter GUARD, default 16, leading cycles of each slot with all digits off (anti-ghosting); legal range 1..SCAN_DIV-1.
REQ-003 Parameter COMMON_ANODE, default 1; 1 makes seg/an/dp active-low, 0 makes them active-high.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  display enable.
REQ-007 d3, d2, d1, d0  input  4 each  digit codes; d3 is leftmost.
REQ-008 dp_in  input  4  decimal-point request; bit k belongs to digit k.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}.
REQ-010 dp  output  1  decimal-point segment.
REQ-011 an  output  4  digit enables; bit k drives digit k.

Function
REQ-012 Slot counter cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; on wrap, digit index idx SHALL advance 0->1->2->3->0.
REQ-013 FSM SHALL have two states: GUARD while cnt<GUARD, DRIVE while cnt>=GUARD; GUARD->DRIVE at cnt==GUARD, DRIVE->GUARD on cnt wrap.
REQ-014 In GUARD, all an bits, all seg bits and dp SHALL be inactive.
REQ-015 In DRIVE, only an[idx] SHALL be active; seg SHALL show the decoded shadow digit idx; dp SHALL equal shadow dp bit idx.
REQ-016 A 20-bit shadow {d3,d2,d1,d0,dp_in} SHALL load when cnt==SCAN_DIV-1 and idx==3, so a frame never mixes old and new digits.
REQ-017 When en=0, cnt and idx SHALL be held at 0, the FSM SHALL be held in GUARD, and the shadow SHALL load every cycle.
REQ-018 When en falls in the same cycle as a wrap, en SHALL take precedence.
REQ-019 seg, dp and an SHALL be registered; pins at edge t+1 reflect FSM, idx and shadow at edge t (1-cycle latency).
REQ-020 Active-high decode: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
REQ-021 When COMMON_ANODE=1, seg, an and dp SHALL be the bitwise inverse of the active-high values.

Reset
REQ-022 With reset high at a clock edge: cnt=0, idx=0, FSM=GUARD, shadow=0, and all outputs inactive (COMMON_ANODE=1: seg=7F, an=F, dp=1).
REQ-023 Reset SHALL override en and any in-progress slot; after release, the first active an appears on the (GUARD+1)th edge.

Configuration
REQ-024 Macro SEG7_HEX_EN defined: codes 10..15 SHALL decode to A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-025 SEG7_HEX_EN undefined: codes 10..15 SHALL blank all segments; dp is unaffected.

Verification (SCAN_DIV=8, GUARD=2, COMMON_ANODE=1, en=1 unless stated)
REQ-026 Release reset with d3..d0=1,2,3,4, dp_in=0 -> edges 1-2: an=F, seg=7F; edges 3-8: an=E; seg shows code 4 (raw active-high 66, pin 19).
REQ-027 Run 32 cycles -> an sequence E,D,B,7, each held 6 cycles with 2 blank cycles between; seg shows codes 4,3,2,1 in turn.
REQ-028 Change d0 to 9 while idx=1 -> the digit-0 slot shows 4 until the frame boundary; the next frame's digit-0 slot shows 9 (raw 6F, pin 10).
REQ-029 Drop en mid-DRIVE -> next edge an=F; on en=1, restart at idx 0 with 2 blank cycles; with d0=C: SEG7_HEX_EN shows raw 39 (pin 46), undefined shows pin 7F.
REQ-030 dp_in=4'b0100, assert reset at cnt=5 of idx 2 -> next edge all outputs inactive; after release, dp=0 only during the idx-2 DRIVE window.
